// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// Opcode and zero flag flow in; enables, selects and debug state flow out.
interface mc_control_fsm_if;
  logic [5:0]  Op;
  logic        Zero;
  logic        PCEn;
  logic [1:0]  PCSel;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic        RegWrite;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOp;
  logic        Illegal;
  logic [3:0]  State;
  logic [31:0] InstrCount;

  modport master (
    input  Op, Zero,
    output PCEn, PCSel, IorD, MemRead, MemWrite,
    output IRWrite, RegDst, MemtoReg, RegWrite,
    output ALUSrcA, ALUSrcB, ALUOp,
    output Illegal, State, InstrCount
  );

  modport slave (
    output Op, Zero,
    input  PCEn, PCSel, IorD, MemRead, MemWrite,
    input  IRWrite, RegDst, MemtoReg, RegWrite,
    input  ALUSrcA, ALUSrcB, ALUOp,
    input  Illegal, State, InstrCount
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/mem/writeback and counts retirements.
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic          clk,
  input  logic          rst,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t      state_q;
  state_t      state_d;
  state_t      state_o;
  logic        illegal_q;
  logic [31:0] instr_count_q;

  logic is_lw, is_sw, is_r, is_beq, is_addi, is_j;
  logic known_op;
  logic retire;
  logic pc_write;
  logic branch;

  assign is_lw    = bus.Op == OP_LW;
  assign is_sw    = bus.Op == OP_SW;
  assign is_r     = bus.Op == OP_RTYPE;
  assign is_beq   = bus.Op == OP_BEQ;
  assign is_addi  = bus.Op == OP_ADDI;
  assign is_j     = bus.Op == OP_J;
  assign known_op = is_lw | is_sw | is_r
                  | is_beq | is_addi | is_j;

  assign retire = (state_q == MEMWB)
                | (state_q == MEMWR)
                | (state_q == RTYPEWB)
                | (state_q == BEQEX)
                | (state_q == ADDIWB)
                | (state_q == JEX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      illegal_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      illegal_q     <= (state_q == DECODE) & ~known_op;
      if (retire)
        instr_count_q <= instr_count_q + 32'd1;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_lw | is_sw: state_d = MEMADR;
          is_r:          state_d = RTYPEEX;
          is_beq:        state_d = BEQEX;
          is_addi:       state_d = ADDIEX;
          is_j:          state_d = JEX;
          default:       state_d = FETCH;
        endcase
      end
      MEMADR: begin
        unique case (1'b1)
          is_lw:   state_d = MEMRD;
          is_sw:   state_d = MEMWR;
          default: state_d = FETCH;
        endcase
      end
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Reset shows FETCH selects; strobes are masked separately below.
  assign state_o = rst ? FETCH : state_q;

  always_comb begin
    pc_write     = 1'b0;
    branch       = 1'b0;
    bus.PCSel    = 2'b00;
    bus.IorD     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = 2'b00;
    bus.ALUOp    = 2'b00;
    case (state_o)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
        pc_write    = 1'b1;
      end
      DECODE:  bus.ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      RTYPEEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      RTYPEWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      BEQEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b01;
        bus.PCSel   = 2'b01;
        branch      = 1'b1;
      end
      ADDIWB:  bus.RegWrite = 1'b1;
      JEX: begin
        bus.PCSel = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      bus.MemRead  = 1'b0;
      bus.MemWrite = 1'b0;
      bus.IRWrite  = 1'b0;
      bus.RegWrite = 1'b0;
    end
  end

  assign bus.PCEn = (pc_write | (branch & bus.Zero)) & ~rst;
  assign bus.Illegal    = illegal_q;
  assign bus.State      = state_o;
  assign bus.InstrCount = instr_count_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control state machine for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath enables and selects, including the 2-bit PC source select consumed by the PC select mux.
- Sits between the instruction register's opcode field and the datapath; also counts retired instructions.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  6  opcode, IR[31:26]; valid from DECODE onward
- Zero  in  1  ALU zero flag
- PCEn  out  1  PC register load enable = PCWrite | (Branch & Zero)
- PCSel  out  2  PC source select: 00 ALUOut (combinational ALU), 01 ALUOutR (registered ALU out), 10 Jaddr; 11 never driven
- IorD  out  1  memory address select: 0 PC, 1 ALUOutR
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  destination select: 0 rt, 1 rd
- MemtoReg  out  1  writeback select: 0 ALUOutR, 1 MDR
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A select: 0 PC, 1 regA
- ALUSrcB  out  2  ALU B select: 00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  2  00 add, 01 subtract, 10 use funct
- Illegal  out  1  one-cycle pulse on an unrecognised opcode
- State  out  4  current state code, for debug
- InstrCount  out  32  retired instruction count

Behaviour:
- Moore machine. A 4-bit state register; all control outputs are decoded combinationally from the state. PCEn additionally uses Zero.
- Default value for every control output not listed for a state is 0; PCSel defaults to 00.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12–15 go to FETCH on the next edge with all outputs at default.
- FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSel=00, PCWrite=1. Next state: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target is computed into ALUOutR). Next state by Op:
  - LW or SW → MEMADR
  - RTYPE → RTYPEEX
  - BEQ → BEQEX
  - ADDI → ADDIEX
  - J → JEX
  - any other opcode → FETCH, with Illegal=1 for the following cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: MEMRD if Op=LW, MEMWR if Op=SW.
- MEMRD: MemRead=1, IorD=1. Next state: MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next state: FETCH.
- MEMWR: MemWrite=1, IorD=1. Next state: FETCH.
- RTYPEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: RTYPEWB.
- RTYPEWB: RegDst=1, MemtoReg=0, RegWrite=1. Next state: FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSel=01. PCEn equals Zero. Next state: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next state: FETCH.
- JEX: PCSel=10, PCWrite=1. Next state: FETCH.
- Cycles per instruction: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Illegal: registered; reset 0; high exactly one cycle (the FETCH after the bad DECODE).
- InstrCount:
  - Registered, 32-bit, wraps from FFFFFFFF to 0.
  - Increments on each edge that moves the state from a completion state (MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX) to FETCH.
  - Does not increment on the illegal-opcode path.
- Reset:
  - On a rising edge with rst=1: state becomes FETCH, InstrCount becomes 0, Illegal becomes 0.
  - While rst=1, PCEn, MemRead, MemWrite, IRWrite and RegWrite are forced to 0; other outputs show FETCH values.
  - Reset asserted mid-instruction abandons it: no count increment, and no write is issued on any edge where rst=1.
- Op and Zero are don't-care outside DECODE/MEMADR and BEQEX, respectively.

Test Plan:
- Reset held 2 cycles then released → State=0, InstrCount=0, all enables 0 while rst=1; first post-reset cycle has MemRead=1, IRWrite=1, PCEn=1, PCSel=00.
- Op=100011 (lw) → states 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 only in state 4; InstrCount increments 0→1 on the 4→0 edge.
- Op=000100 (beq), Zero=1 in BEQEX → PCSel=01, PCEn=1 for that cycle; repeat with Zero=0 → PCEn=0; 3 cycles each, count +1 each.
- Op=000010 (j) → state 11 shows PCSel=10, PCEn=1, RegWrite=0; back to FETCH after 3 cycles total.
- Op=111111 → DECODE to FETCH, Illegal=1 for one cycle, InstrCount unchanged.
- rst asserted during RTYPEEX → next state FETCH, RegWrite never asserted, InstrCount unchanged. Separately, preload via 2^32−1 retires (or force) → count wraps to 0.
